// File: rtl/mult_share_arbiter_pkg.sv
// Shared widths, stage bundles and round-robin helper for mult_share_arbiter.
package mult_share_pkg;

    localparam int DATA_W = 16;
    localparam int PROD_W = 2 * DATA_W;
    localparam int ID_W   = 3;

    typedef struct packed {
        logic              valid;
        logic [ID_W-1:0]   id;
        logic [DATA_W-1:0] a;
        logic [DATA_W-1:0] b;
    } op_stage_t;

    typedef struct packed {
        logic              valid;
        logic [ID_W-1:0]   id;
        logic [PROD_W-1:0] product;
    } prod_stage_t;

    function automatic int rr_wrap(input int idx, input int n);
        return (idx >= n) ? idx - n : idx;
    endfunction

endpackage

// File: rtl/mult_share_arbiter_booth.sv
// Booth_Multiplier_Routing: combinational radix-4 Booth signed multiplier.
module Booth_Multiplier_Routing #(
    parameter int DATA_W = 16
) (
    input  logic [DATA_W-1:0]   a,
    input  logic [DATA_W-1:0]   b,
    output logic [2*DATA_W-1:0] product
);

    localparam int NG = (DATA_W + 1) / 2;
    localparam int BW = 2 * NG + 1;
    localparam int PW = 2 * DATA_W;

    logic signed [DATA_W-1:0] as_s;
    logic signed [DATA_W-1:0] bs_s;
    logic signed [BW-2:0]     bs_x;
    logic        [BW-1:0]     bx;
    logic signed [PW-1:0]     ax;
    logic signed [PW-1:0]     pp;
    logic signed [PW-1:0]     acc;

    assign as_s = a;
    assign bs_s = b;

    always_comb begin
        bs_x = (BW-1)'(bs_s);
        // bit 0 is the implicit b[-1] = 0 of the first Booth group
        bx   = {bs_x, 1'b0};
        ax   = PW'(as_s);
        acc  = '0;
        pp   = '0;
        for (int g = 0; g < NG; g++) begin
            unique case (bx[2*g +: 3])
                3'b001, 3'b010: pp = ax;
                3'b011:         pp = ax <<< 1;
                3'b100:         pp = -(ax <<< 1);
                3'b101, 3'b110: pp = -ax;
                default:        pp = '0;
            endcase
            acc = acc + (pp <<< (2 * g));
        end
        product = acc;
    end

endmodule

// File: rtl/mult_share_arbiter.sv
// Round-robin shared signed multiplier; define MULT_SHARE_ARBITER_PIPE_EN
// to add a register after the multiplier (latency 2 instead of 1).
module mult_share_arbiter
    import mult_share_pkg::*;
#(
    parameter int NUM_REQ = 4,
    parameter int DATA_W  = mult_share_pkg::DATA_W
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic [NUM_REQ-1:0]               req_valid,
    output logic [NUM_REQ-1:0]               req_ready,
    input  logic [NUM_REQ-1:0][DATA_W-1:0]   req_a,
    input  logic [NUM_REQ-1:0][DATA_W-1:0]   req_b,
    output logic                             rsp_valid,
    input  logic                             rsp_ready,
    output logic [$clog2(NUM_REQ)-1:0]       rsp_id,
    output logic [2*DATA_W-1:0]              rsp_product
);

    localparam int IDW = $clog2(NUM_REQ);
    localparam int PW  = 2 * DATA_W;

    typedef struct packed {
        logic              valid;
        logic [IDW-1:0]    id;
        logic [DATA_W-1:0] a;
        logic [DATA_W-1:0] b;
    } op_t;

    typedef struct packed {
        logic           valid;
        logic [IDW-1:0] id;
        logic [PW-1:0]  product;
    } pr_t;

    op_t            op_q;
    pr_t            out_q;
    pr_t            mul_s;
    logic [IDW-1:0] rr_ptr;
    logic [IDW-1:0] win;
    logic           found;
    logic           adv;
    logic [PW-1:0]  mul_p;

    // every stage moves together; only a held output blocks the pipe
    assign adv = !out_q.valid || rsp_ready;

    always_comb begin
        win   = '0;
        found = 1'b0;
        for (int k = 0; k < NUM_REQ; k++) begin
            int idx;
            idx = rr_wrap(int'(rr_ptr) + k, NUM_REQ);
            if (!found && req_valid[idx]) begin
                found = 1'b1;
                win   = IDW'(idx);
            end
        end
    end

    always_comb begin
        req_ready = '0;
        if (adv && found && !rst)
            req_ready[win] = 1'b1;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            rr_ptr <= '0;
        else if (adv && found)
            rr_ptr <= IDW'(rr_wrap(int'(win) + 1, NUM_REQ));
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            op_q <= '0;
        end else if (adv) begin
            op_q.valid <= found;
            op_q.id    <= win;
            op_q.a     <= req_a[win];
            op_q.b     <= req_b[win];
        end
    end

    Booth_Multiplier_Routing #(
        .DATA_W (DATA_W)
    ) u_mul (
        .a       (op_q.a),
        .b       (op_q.b),
        .product (mul_p)
    );

    assign mul_s = '{valid: op_q.valid, id: op_q.id, product: mul_p};

`ifdef MULT_SHARE_ARBITER_PIPE_EN
    pr_t mid_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mid_q <= '0;
            out_q <= '0;
        end else if (adv) begin
            mid_q <= mul_s;
            out_q <= mid_q;
        end
    end
`else
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            out_q <= '0;
        else if (adv)
            out_q <= mul_s;
    end
`endif

    assign rsp_valid   = out_q.valid;
    assign rsp_id      = out_q.id;
    assign rsp_product = out_q.product;

endmodule

// File: doc/mult_share_arbiter.md
MULT_SHARE_ARBITER -- requirements
Module: mult_share_arbiter

Interface
REQ-001 The block SHALL have parameter NUM_REQ, default 4, meaning the number of requesters sharing one multiplier (2..8).
REQ-002 The block SHALL have parameter DATA_W, default 16, meaning the operand width; product width is 2*DATA_W.
REQ-003 The block SHALL have port clk, input, 1, the single clock; all state changes on its rising edge.
REQ-004 The block SHALL have port rst, input, 1, an asynchronous active-high reset.
REQ-005 The block SHALL have port req_valid, input, NUM_REQ, the per-requester operand-valid flags.
REQ-006 The block SHALL have port req_ready, output, NUM_REQ, the per-requester accept flags (one-hot or zero).
REQ-007 The block SHALL have port req_a, input, NUM_REQ x DATA_W, the per-requester multiplicands, signed two's complement.
REQ-008 The block SHALL have port req_b, input, NUM_REQ x DATA_W, the per-requester multipliers, signed two's complement.
REQ-009 The block SHALL have port rsp_valid, output, 1, meaning the result register holds a product.
REQ-010 The block SHALL have port rsp_ready, input, 1, the consumer accept flag.
REQ-011 The block SHALL have port rsp_id, output, clog2(NUM_REQ), the index of the requester owning the product.
REQ-012 The block SHALL have port rsp_product, output, 2*DATA_W, the signed product.

Function
REQ-013 Transfer on a request: req_valid[i] && req_ready[i] at a rising edge; transfer on a response: rsp_valid && rsp_ready.
REQ-014 Arbitration SHALL be round-robin: search starts at index rr_ptr, first requester with req_valid wins; rr_ptr becomes winner+1 (mod NUM_REQ) only on an accepted request.
REQ-015 req_ready SHALL be one-hot at the winner when the pipeline can advance (output stage empty or rsp_ready high), else all zero; it depends combinationally on req_valid, rr_ptr, rsp_ready.
REQ-016 Accepted operands SHALL be registered in the operand stage; the product SHALL be computed combinationally from the operand stage and captured in the output stage.
REQ-017 Latency: request accepted at edge t -> rsp_valid high after edge t+1; sustained throughput one product per cycle while rsp_ready is high.
REQ-018 Stall: while rsp_valid && !rsp_ready, rsp_product, rsp_id and all pipeline stages SHALL hold and no request is accepted.
REQ-019 Simultaneous response transfer and new request acceptance in the same cycle SHALL be allowed without bubble.
REQ-020 Products SHALL be exact signed 2*DATA_W results; no truncation or saturation; -32768 * -32768 = 0x40000000.
REQ-021 A requester deasserting req_valid before acceptance SHALL lose no state; no request is dropped or duplicated.
REQ-022 Each stage SHALL carry a valid bit and requester id; bubbles propagate as invalid.

Reset
REQ-023 On rst high, req_ready=0, rsp_valid=0, rsp_id=0, rsp_product=0, rr_ptr=0 and all stage valid bits clear, immediately and asynchronously.
REQ-024 Reset mid-operation SHALL discard all in-flight operands and products without emitting them; first accepted request after reset is from the lowest valid index.

Configuration
REQ-025 Macro MULT_SHARE_ARBITER_PIPE_EN, when defined, SHALL insert one extra register between multiplier output and output stage, making latency 2 (rsp_valid after edge t+2) with the same stall and no-bubble rules across all three stages.
REQ-026 Without MULT_SHARE_ARBITER_PIPE_EN, latency SHALL be 1 as in REQ-017; ports and arbitration are identical in both builds.

Structure
REQ-027 A shared package mult_share_pkg SHALL hold the DATA_W default, product-width constant and a stage struct typedef (valid, id, a, b / product).
REQ-028 The block SHALL instantiate exactly one sub-module, the team's existing Booth_Multiplier_Routing, as the combinational multiplier; the round-robin picker stays inline.

Verification
REQ-029 Single requester 0: a=100, b=12 -> rsp_valid one cycle later, rsp_id=0, rsp_product=1200.
REQ-030 All 4 requesters valid every cycle, rsp_ready=1 -> grants in order 0,1,2,3,0, one product per cycle, ids match.
REQ-031 Req 2: a=-3, b=5 and Req 1: a=85, b=30 together -> req 1 first (2550), then req 2 (0xFFFFFFF1).
REQ-032 rsp_ready low for 5 cycles with product 90*4 held -> rsp_product stays 360, req_ready all zero, no loss after release.
REQ-033 rst pulsed while two products in flight -> rsp_valid drops immediately, no stale product emitted after release.
REQ-034 Rerun REQ-029..REQ-033 with MULT_SHARE_ARBITER_PIPE_EN defined -> identical results with latency 2.
